// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - single-outstanding request initiator for a single-port synchronous RAM
// Optional RAM_ACCESS_CTRL_CLEAR_EN adds a sequential zero-fill (CLEAR) of the whole RAM.
module ram_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
`endif
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAPT  = 3'd2,
        RESP  = 3'd3
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        ,
        CLEAR = 3'd4
`endif
    } state_t;

    state_t            r_state;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_clear_req;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    logic              r_clear_busy;
    logic              r_clear_done;
    logic [ADDR_W-1:0] r_clr_cnt;

    assign w_clear_req = clear_start;
    assign clear_busy  = r_clear_busy;
    assign clear_done  = r_clear_done;
`else
    assign w_clear_req = 1'b0;
`endif

    assign req_ready    = (r_state == IDLE) && !w_clear_req;
    assign rsp_valid    = (r_state == RESP);
    assign rsp_write    = r_rsp_write;
    assign rsp_rdata    = r_rsp_rdata;
    assign ram_write_en = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_data_in  = r_ram_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_clr_cnt    <= '0;
`endif
        end else begin
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
            r_clear_done <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
                    if (clear_start) begin
                        r_ram_addr   <= '0;
                        r_ram_din    <= '0;
                        r_ram_we     <= 1'b1;
                        r_clr_cnt    <= '0;
                        r_clear_busy <= 1'b1;
                        r_state      <= CLEAR;
                    end else
`endif
                    if (req_valid) begin
                        r_ram_addr <= req_addr;
                        if (req_write) begin
                            r_ram_din <= req_wdata;
                        end
                        r_ram_we <= req_write;
                        r_state  <= ISSUE;
                    end
                end
                // The write enable doubles as the request-type flag while in ISSUE.
                ISSUE: begin
                    if (r_ram_we) begin
                        r_ram_we    <= 1'b0;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_state <= CAPT;
                    end
                end
                CAPT: begin
                    r_rsp_rdata <= ram_data_out;
                    r_rsp_write <= 1'b0;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
                CLEAR: begin
                    if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                        r_ram_we     <= 1'b0;
                        r_clear_busy <= 1'b0;
                        r_clear_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_clr_cnt  <= r_clr_cnt + 1'b1;
                        r_ram_addr <= r_clr_cnt + 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed scoreboard bench for ram_access_ctrl with a behavioural RAM
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic        ram_write_en;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data_in, ram_data_out;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    logic        clear_start, clear_busy, clear_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    logic [31:0] ram_mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_addr] <= ram_data_in;
        ram_data_out <= ram_mem[ram_addr];
    end

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
`endif
        .ram_write_en(ram_write_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_ram_we"}, {31'd0, ram_write_en}, 32'd0);
        check({tag, "_ram_addr"}, {24'd0, ram_addr}, 32'd0);
        check({tag, "_ram_din"}, ram_data_in, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d, input int stall);
        exp_t e;
        int   lat;
        int   we_cnt;
        e.wr    = wr;
        e.rdata = wr ? 32'd0 : ref_mem[a];
        if (wr) ref_mem[a] = d;
        sb.push_back(e);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        rsp_ready = (stall == 0);
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("ram_addr_after_accept", {24'd0, ram_addr}, {24'd0, a});
        if (wr) check("ram_din_after_accept", ram_data_in, d);
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        we_cnt = int'(ram_write_en);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            we_cnt += int'(ram_write_en);
        end
        check("rsp_latency", lat, wr ? 32'd1 : 32'd2);
        check("ram_we_cycles", we_cnt, wr ? 32'd1 : 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
            check("rsp_rdata", rsp_rdata, e.rdata);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                check("stall_rsp_rdata", rsp_rdata, e.rdata);
                check("stall_rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
                check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("retired_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("retired_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        clear_start = 1'b0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 8'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 8'h10, 32'h0, 0);
        do_req(1'b1, 8'hFF, 32'hA5A55A5A, 0);
        do_req(1'b0, 8'hFF, 32'h0, 5);
        do_req(1'b1, 8'h00, 32'h13579BDF, 0);
        do_req(1'b1, 8'h01, 32'hFFFFFFFF, 3);
        do_req(1'b0, 8'h00, 32'h0, 2);
        do_req(1'b0, 8'h01, 32'h0, 0);

        // Abort a read while it sits in CAPT.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        @(negedge clk);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 8'h10, 32'h0, 0);

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        begin
            int cnt;
            int budget;
            do_req(1'b1, 8'h80, 32'h00001234, 0);
            clear_start = 1'b1;
            req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h22; req_wdata = 32'h5;
            check("clear_blocks_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            clear_start = 1'b0; req_valid = 1'b0;
            check("clear_busy_on", {31'd0, clear_busy}, 32'd1);
            cnt = 0;
            budget = 0;
            while (!clear_done && budget < 400) begin
                if (ram_write_en) begin
                    check("clear_addr_seq", {24'd0, ram_addr}, cnt);
                    check("clear_data_zero", ram_data_in, 32'd0);
                    cnt++;
                end
                @(negedge clk);
                budget++;
            end
            check("clear_done_seen", {31'd0, clear_done}, 32'd1);
            check("clear_write_count", cnt, 32'd256);
            check("clear_busy_off", {31'd0, clear_busy}, 32'd0);
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
            @(negedge clk);
            check("clear_done_pulse", {31'd0, clear_done}, 32'd0);
            do_req(1'b0, 8'h80, 32'h0, 0);
            do_req(1'b0, 8'h22, 32'h0, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width (256 words).
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port req_valid / req_ready, input / output, 1 / 1, request handshake; transfer on the edge where both are high.
REQ-006 Port req_write, input, 1, 1 = write, 0 = read.
REQ-007 Port req_addr, input, ADDR_W, request address.
REQ-008 Port req_wdata, input, DATA_W, write data.
REQ-009 Port rsp_valid / rsp_ready, output / input, 1 / 1, response handshake.
REQ-010 Port rsp_write, output, 1, type of completed request.
REQ-011 Port rsp_rdata, output, DATA_W, read data; 0 for write responses.
REQ-012 Port ram_write_en, output, 1, drives the RAM write enable.
REQ-013 Port ram_addr, output, ADDR_W, drives the RAM address.
REQ-014 Port ram_data_in, output, DATA_W, drives the RAM write data.
REQ-015 Port ram_data_out, input, DATA_W, RAM registered read data, valid the cycle after the RAM samples a read.

Function
REQ-016 The block SHALL be the initiator for the single-port synchronous RAM: at most one request outstanding at a time.
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPT, RESP and CLEAR (CLEAR only with macro).
REQ-018 req_ready SHALL be high only in IDLE, and low when clear_start is high (macro builds only).
REQ-019 Accept edge E0: ram_addr <= req_addr; ram_data_in <= req_wdata (write) or unchanged (read); ram_write_en <= req_write; next state ISSUE.
REQ-020 Write in ISSUE: at E1 the state SHALL go to RESP, with ram_write_en <= 0, rsp_write <= 1 and rsp_rdata <= 0; rsp_valid high from E1.
REQ-021 Read in ISSUE: at E1 the state SHALL go to CAPT; at E2 rsp_rdata <= ram_data_out, rsp_write <= 0 and the state goes to RESP; rsp_valid high from E2.
REQ-022 rsp_valid SHALL equal (state == RESP); rsp_rdata and rsp_write SHALL hold while rsp_valid && !rsp_ready.
REQ-023 In RESP, on an edge with rsp_ready high, the state SHALL go to IDLE; the next request is acceptable one cycle later.
REQ-024 ram_write_en SHALL be high only in ISSUE-for-write and CLEAR; ram_addr and ram_data_in hold their last values otherwise.
REQ-025 Address arithmetic SHALL be unsigned ADDR_W bits; addresses 0 and 2^ADDR_W-1 are legal with no special casing.

Reset
REQ-026 rst high at an edge SHALL force IDLE, and SHALL clear ram_write_en, ram_addr, ram_data_in, rsp_rdata, rsp_write, clear_busy, clear_done and the clear counter to 0.
REQ-027 Reset mid-transaction or mid-clear SHALL abort without a response; req_ready is high the first cycle after rst deasserts.
REQ-028 The block SHALL NOT drive the RAM's own reset.

Configuration
REQ-029 Macro RAM_ACCESS_CTRL_CLEAR_EN SHALL add the ports clear_start (input, 1), clear_busy (output, 1) and clear_done (output, 1), plus the CLEAR state.
REQ-030 With the macro: clear_start in IDLE SHALL enter CLEAR and win over a simultaneous req_valid; clear_start outside IDLE SHALL be ignored.
REQ-031 In CLEAR, the block SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, in ascending order, with clear_busy high.
REQ-032 After the last address write, the block SHALL return to IDLE with clear_done as a one-cycle pulse (256 write cycles at default).
REQ-033 Without the macro, the ports, CLEAR state and counter SHALL be absent; behaviour is otherwise identical.

Verification
REQ-034 Write 0xDEADBEEF to addr 0x10, rsp_ready=1 -> ram_write_en high exactly 1 cycle, rsp_valid at E1 with rsp_write=1 and rsp_rdata=0.
REQ-035 Read addr 0x10 after REQ-034 -> rsp_valid at E2, rsp_rdata=0xDEADBEEF, rsp_write=0.
REQ-036 Read addr 0xFF with rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable 5 cycles, req_ready low, retire on the 6th edge.
REQ-037 Assert rst while in CAPT -> no rsp_valid, all outputs 0, next request accepted normally.
REQ-038 Macro on: write 0x1234 to addr 0x80, then clear_start with req_valid also high -> request not accepted, 256 zero writes, clear_done pulse, read 0x80 returns 0.
